// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse position tracker: FSM states, register
// offsets within the bus window and status register bit positions.
package mouse_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  localparam logic [7:0] STATUS_OFS = 8'd0;
  localparam logic [7:0] X_OFS      = 8'd1;
  localparam logic [7:0] Y_OFS      = 8'd2;
  localparam logic [7:0] WIN_SIZE   = 8'd3;

  localparam int ST_BIT_OVR = 7;
  localparam int ST_BIT_L   = 3;
  localparam int ST_BIT_R   = 2;
  localparam int ST_BIT_XS  = 1;
  localparam int ST_BIT_YS  = 0;

  // Bus writes saturate at the top of the axis range.
  function automatic logic [7:0] clamp_wr(input logic [7:0] v, input logic [7:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Combinational per-axis position step: pos +/- 10-bit signed delta,
// saturated to 0..LIMIT-1.
module mouse_axis_clamp #(
  parameter int LIMIT = 160
) (
  input  logic [7:0] pos,
  input  logic [9:0] delta,
  input  logic       sub,
  output logic [7:0] result
);

  localparam logic signed [10:0] MAX_V = 11'(LIMIT - 1);

  // One extra bit so that subtracting the most negative delta cannot wrap.
  logic signed [10:0] pos_ext;
  logic signed [10:0] dlt_ext;
  logic signed [10:0] sum;

  always_comb begin
    pos_ext = $signed({3'b000, pos});
    dlt_ext = $signed({delta[9], delta});
    sum     = sub ? (pos_ext - dlt_ext) : (pos_ext + dlt_ext);
    if (sum < 0)          result = 8'd0;
    else if (sum > MAX_V) result = MAX_V[7:0];
    else                  result = sum[7:0];
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// Tracks a clamped screen cursor position from mouse packets and exposes
// status/X/Y through a 3-register processor bus window with interrupt.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int         LIMIT_X   = 160,
  parameter int         LIMIT_Y   = 120,
  parameter logic [7:0] BASE_ADDR = 8'hA0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic       SEND_INTERRUPT,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] BUS_DATA_IN,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OUT_EN,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [7:0] X_MAX = 8'(LIMIT_X - 1);
  localparam logic [7:0] Y_MAX = 8'(LIMIT_Y - 1);
  localparam logic [7:0] X_RST = 8'(LIMIT_X / 2);
  localparam logic [7:0] Y_RST = 8'(LIMIT_Y / 2);

  logic [0:0] state_q, state_d;
  logic [3:0] pkt_st_q, pkt_st_d;
  logic [7:0] pkt_dx_q, pkt_dx_d;
  logic [7:0] pkt_dy_q, pkt_dy_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       ovr_q, ovr_d;
  logic       raise_q, raise_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_en_q, dout_en_d;

  logic [7:0] ofs;
  logic       in_win, rd, wr, upd;
  logic [9:0] dx_ext, dy_ext;
  logic [7:0] x_new, y_new;
  logic [7:0] status_reg;

  assign ofs        = BUS_ADDR - BASE_ADDR;
  assign in_win     = (ofs < WIN_SIZE);
  assign rd         = in_win && !BUS_WE;
  assign wr         = in_win && BUS_WE;
  assign upd        = (state_q == ST_UPDATE);
  assign dx_ext     = {pkt_st_q[ST_BIT_XS], pkt_st_q[ST_BIT_XS], pkt_dx_q};
  assign dy_ext     = {pkt_st_q[ST_BIT_YS], pkt_st_q[ST_BIT_YS], pkt_dy_q};
  assign status_reg = {ovr_q, 3'b000, pkt_st_q};

  mouse_axis_clamp #(.LIMIT(LIMIT_X)) u_clamp_x (
    .pos(x_q), .delta(dx_ext), .sub(1'b0), .result(x_new)
  );

  // Mouse-up is positive dY but screen-up is decreasing Y.
  mouse_axis_clamp #(.LIMIT(LIMIT_Y)) u_clamp_y (
    .pos(y_q), .delta(dy_ext), .sub(1'b1), .result(y_new)
  );

  always_comb begin
    state_d  = SEND_INTERRUPT ? ST_UPDATE : ST_IDLE;
    pkt_st_d = pkt_st_q;
    pkt_dx_d = pkt_dx_q;
    pkt_dy_d = pkt_dy_q;
    if (SEND_INTERRUPT) begin
      pkt_st_d = MOUSE_STATUS;
      pkt_dx_d = MOUSE_DX;
      pkt_dy_d = MOUSE_DY;
    end

    x_d = upd ? x_new : x_q;
    y_d = upd ? y_new : y_q;
    if (wr && ofs == X_OFS) x_d = clamp_wr(BUS_DATA_IN, X_MAX);
    if (wr && ofs == Y_OFS) y_d = clamp_wr(BUS_DATA_IN, Y_MAX);

    raise_d = raise_q;
    if (BUS_INTERRUPT_ACK) raise_d = 1'b0;
    if (upd)               raise_d = 1'b1;

    // Overrun: a new update lands before the previous one was acknowledged.
    ovr_d = ovr_q;
    if (rd && ofs == STATUS_OFS)               ovr_d = 1'b0;
    if (upd && raise_q && !BUS_INTERRUPT_ACK) ovr_d = 1'b1;

    dout_en_d = rd;
    dout_d    = 8'd0;
    if (rd) begin
      case (ofs)
        STATUS_OFS: dout_d = status_reg;
        X_OFS:      dout_d = x_q;
        default:    dout_d = y_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      pkt_st_q  <= 4'd0;
      pkt_dx_q  <= 8'd0;
      pkt_dy_q  <= 8'd0;
      x_q       <= X_RST;
      y_q       <= Y_RST;
      ovr_q     <= 1'b0;
      raise_q   <= 1'b0;
      dout_q    <= 8'd0;
      dout_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_st_q  <= pkt_st_d;
      pkt_dx_q  <= pkt_dx_d;
      pkt_dy_q  <= pkt_dy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ovr_q     <= ovr_d;
      raise_q   <= raise_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign BUS_DATA_OUT        = dout_q;
  assign BUS_DATA_OUT_EN     = dout_en_q;
  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: doc/mouse_position_tracker.md
MOUSE_POSITION_TRACKER -- requirements
Module: mouse_position_tracker

Interface
REQ-001 Parameter LIMIT_X, default 160: X extent; X position range is 0..LIMIT_X-1.
REQ-002 Parameter LIMIT_Y, default 120: Y extent; Y position range is 0..LIMIT_Y-1.
REQ-003 Parameter BASE_ADDR, default 8'hA0: base of the 3-register bus window.
REQ-004 CLK  input  1  system clock, all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 MOUSE_STATUS  input  4  {L, R, X_sign, Y_sign}, bit3 = L, from the mouse transceiver.
REQ-007 MOUSE_DX  input  8  X delta magnitude bits; sign is MOUSE_STATUS[1].
REQ-008 MOUSE_DY  input  8  Y delta magnitude bits; sign is MOUSE_STATUS[0].
REQ-009 SEND_INTERRUPT  input  1  one-cycle pulse; packet inputs valid in the same cycle.
REQ-010 BUS_ADDR  input  8  processor bus address.
REQ-011 BUS_WE  input  1  processor write strobe.
REQ-012 BUS_DATA_IN  input  8  processor write data.
REQ-013 BUS_DATA_OUT  output  8  registered read data.
REQ-014 BUS_DATA_OUT_EN  output  1  high when BUS_DATA_OUT drives the shared bus.
REQ-015 BUS_INTERRUPT_RAISE  output  1  level interrupt request to the processor.
REQ-016 BUS_INTERRUPT_ACK  input  1  one-cycle interrupt acknowledge.

Function
REQ-017 The FSM SHALL have two states: IDLE and UPDATE.
- IDLE -> UPDATE on SEND_INTERRUPT.
- UPDATE -> IDLE otherwise.
- UPDATE -> UPDATE when SEND_INTERRUPT is high in UPDATE.
REQ-018 On SEND_INTERRUPT, in any state, the block SHALL capture MOUSE_STATUS, MOUSE_DX and MOUSE_DY into packet registers.
REQ-019 Deltas SHALL be sign-extended to 10-bit two's complement as {sign, sign, DX}.
REQ-020 In UPDATE, X SHALL become clamp(X + dX, 0, LIMIT_X-1), computed at 10 bits with no wrap-around.
REQ-021 In UPDATE, Y SHALL become clamp(Y - dY, 0, LIMIT_Y-1), because mouse-up means screen-up.
REQ-022 Latency: with SEND_INTERRUPT in cycle N, new X/Y and the raise SHALL be visible from cycle N+2.
REQ-023 BUS_INTERRUPT_RAISE SHALL be set on every UPDATE cycle and cleared by BUS_INTERRUPT_ACK.
- If set and ACK occur in the same cycle, set wins.
REQ-024 The status register SHALL be {OVR, 3'b0, L, R, Xs, Ys}.
- OVR sets when UPDATE occurs while RAISE is already high and ACK is absent.
REQ-025 Register map:
- BASE+0 is status, read-only.
- BASE+1 is X, read/write.
- BASE+2 is Y, read/write.
REQ-026 A read (BUS_WE low, address in window) in cycle N SHALL drive BUS_DATA_OUT and BUS_DATA_OUT_EN in cycle N+1 only.
- Outside reads, BUS_DATA_OUT_EN SHALL be low.
REQ-027 A read of BASE+0 SHALL clear OVR at the end of the read cycle; a simultaneous OVR set wins.
REQ-028 A write to BASE+1 or BASE+2 SHALL load the value clamped to LIMIT-1.
- In the same cycle as UPDATE, the write wins for that axis only.
REQ-029 Writes to BASE+0 and accesses outside the window SHALL be ignored.

Reset
REQ-030 While RESET is low, the block SHALL hold the following values:
- State IDLE.
- X = LIMIT_X/2 and Y = LIMIT_Y/2.
- Packet registers 0 and OVR 0.
- BUS_INTERRUPT_RAISE 0, BUS_DATA_OUT 0 and BUS_DATA_OUT_EN 0.
REQ-031 Reset asserted mid-UPDATE SHALL abort the update; no position change and no raise follow reset release.

Structure
REQ-032 The shared mouse package SHALL hold:
- the state enum;
- register offsets STATUS_OFS = 0, X_OFS = 1, Y_OFS = 2;
- the status bit index constants.
REQ-033 One sub-module, mouse_axis_clamp, SHALL perform the 10-bit signed add and clamp to 0..LIMIT-1.
- It SHALL be combinational and parameterised by LIMIT.
- It SHALL be instantiated twice, once per axis.

Verification
REQ-034 After reset release, reading BASE+1 and BASE+2 -> 80 and 60; RAISE = 0.
REQ-035 Packet DX = 8'h05, Xs = 0, DY = 8'h03, Ys = 0 -> from N+2: X = 85, Y = 57, RAISE = 1.
- ACK then clears RAISE; OVR = 0.
REQ-036 Packet DX = 8'h80, Xs = 1 (-128) from X = 80 -> X = 0.
- Packet DX = 8'hFF, Xs = 0 from X = 150 -> X = 159.
REQ-037 Two packets with no ACK between them -> RAISE stays 1 and status bit7 = 1.
- A read of BASE+0 returns 8'h8x and then bit7 = 0.
REQ-038 Write 200 to BASE+2 -> Y = 119.
- A write to BASE+1 in the same cycle as UPDATE -> X equals the written value.
REQ-039 RESET pulsed low the cycle after SEND_INTERRUPT -> X = 80, Y = 60 and RAISE = 0 after release, with no later update.
